// File: rtl/cic_pkg.sv
// Shared constants and constant functions for the CIC interpolator and its
// receive-side twin, the CIC decimator.
//   clog2_int   : ceil(log2(v)), written as a bounded loop so it can also be
//                 evaluated inside always_comb with an unrolled loop index.
//   ratio_width : width of the ratio port for a given maximum ratio.
//   acc_width   : width of comb/integrator registers (worst-case bit growth).
//   round_msb   : MSB of the accumulator slice that becomes the output for a
//                 given ratio R; the slice below it divides out R^(N-1).
package cic_pkg;

  localparam int MIN_INTERP_DEFAULT = 2;
  localparam int MAX_INTERP_DEFAULT = 40;
  localparam int IN_WIDTH_DEFAULT   = 18;
  localparam int OUT_WIDTH_DEFAULT  = 18;

  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ratio_width(input int max_r);
    return clog2_int(max_r);
  endfunction

  function automatic int acc_width(input int in_w, input int stages, input int max_r);
    return in_w + stages * clog2_int(max_r);
  endfunction

  function automatic int round_msb(input int in_w, input int stages, input int r);
    return in_w + (stages - 1) * clog2_int(r) - 1;
  endfunction

endpackage

// File: rtl/cic_interpolator_if.sv
// Sample-stream interface of the CIC interpolator.
//   out_strobe : high-rate tick from the downstream DAC/modulator (master drives)
//   in_valid   : upstream sample present on in_data        (master drives)
//   in_data    : signed input sample                       (master drives)
//   in_ready   : sample is consumed on this tick           (slave drives)
//   out_valid  : one-cycle pulse after each out_strobe     (slave drives)
//   out_data   : signed rounded output sample              (slave drives)
interface cic_interpolator_if
  import cic_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEFAULT,
  parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT
);
  logic                        out_strobe;
  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;

  modport master (
    output out_strobe, in_valid, in_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  out_strobe, in_valid, in_data,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cic_round.sv
// Variable-position truncate-and-round of a wide accumulator.
//   acc     : signed accumulator value
//   msb     : index of the accumulator bit that becomes the output sign bit
//   rounded : acc[msb -: OUT_WIDTH] plus the bit just below the slice (when
//             such a bit exists). If msb sits below OUT_WIDTH-1 the value is
//             shifted up instead, with no rounding bit.
module cic_round #(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 18,
  parameter int MSB_W     = 6
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic        [MSB_W-1:0]     msb,
  output logic signed [OUT_WIDTH-1:0] rounded
);

  int                        lsb;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic        [ACC_WIDTH-1:0] below;
  logic                        rnd_bit;

  always_comb begin
    lsb     = int'(msb) - OUT_WIDTH + 1;
    shifted = acc;
    below   = '0;
    rnd_bit = 1'b0;
    if (lsb > 0) begin
      shifted = acc >>> lsb;
      below   = acc >> (lsb - 1);
      rnd_bit = below[0];
    end else if (lsb < 0) begin
      shifted = acc <<< (-lsb);
    end
    // Half-LSB round; a positive value at the top of range wraps, which the
    // normalised gain keeps out of reach for in-range inputs.
    rounded = shifted[OUT_WIDTH-1:0] + OUT_WIDTH'(rnd_bit);
  end

endmodule

// File: rtl/cic_interpolator.sv
// Cascaded comb-integrator interpolating filter for the transmit path.
// Combs run at the input rate (on load ticks), the comb output is
// zero-stuffed, and integrators run at the output rate (every out_strobe).
// The output slice position depends on R so that the passband gain R^(N-1)
// is divided back out.
//   clock           : single clock
//   reset_n         : asynchronous active-low reset, clears all state
//   interpolation   : ratio R (MIN..MAX); ignored in a fixed-rate build
//   clear_underflow : synchronous clear of the sticky underflow flag
//   underflow       : set when a sample was needed but in_valid was low
//   bus             : sample stream (strobe, valid/data/ready, output)
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int STAGES            = 5,
  parameter int MIN_INTERPOLATION = MIN_INTERP_DEFAULT,
  parameter int MAX_INTERPOLATION = MAX_INTERP_DEFAULT,
  parameter int IN_WIDTH          = IN_WIDTH_DEFAULT,
  parameter int OUT_WIDTH         = OUT_WIDTH_DEFAULT
) (
  input  logic                                      clock,
  input  logic                                      reset_n,
  input  logic [ratio_width(MAX_INTERPOLATION)-1:0] interpolation,
  input  logic                                      clear_underflow,
  output logic                                      underflow,
  cic_interpolator_if.slave                         bus
);

  localparam int ACC_WIDTH = acc_width(IN_WIDTH, STAGES, MAX_INTERPOLATION);
  localparam int R_W       = ratio_width(MAX_INTERPOLATION);
  localparam int MSB_W     = clog2_int(ACC_WIDTH);
  localparam bit FIXED     = (MIN_INTERPOLATION == MAX_INTERPOLATION);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [R_W-1:0]              phase_q, phase_d;
  acc_t                        comb_data_q [1:STAGES];
  acc_t                        comb_data_d [1:STAGES];
  acc_t                        comb_last_q [0:STAGES-1];
  acc_t                        comb_last_d [0:STAGES-1];
  acc_t                        integrator_q [1:STAGES];
  acc_t                        integrator_d [1:STAGES];
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        underflow_q, underflow_d;

  logic                        load_tick;
  acc_t                        x_ext;
  acc_t                        z;
  logic [R_W:0]                ratio;
  logic [MSB_W-1:0]            msb_sel;
  logic signed [OUT_WIDTH-1:0] rounded;

  // Output slice position per ratio; out-of-range ratios fall back to MAX.
  always_comb begin
    msb_sel = MSB_W'(round_msb(IN_WIDTH, STAGES, MAX_INTERPOLATION));
    if (!FIXED) begin
      for (int r = MIN_INTERPOLATION; r <= MAX_INTERPOLATION; r++) begin
        if (interpolation == R_W'(r)) msb_sel = MSB_W'(round_msb(IN_WIDTH, STAGES, r));
      end
    end
  end

  cic_round #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .MSB_W     (MSB_W)
  ) u_round (
    .acc     (integrator_q[STAGES]),
    .msb     (msb_sel),
    .rounded (rounded)
  );

  always_comb begin
    ratio     = FIXED ? (R_W+1)'(MAX_INTERPOLATION) : {1'b0, interpolation};
    load_tick = bus.out_strobe && (phase_q == '0);
    x_ext     = bus.in_valid ? acc_t'(bus.in_data) : '0;

    // Wrap on ">=" so that lowering R mid-run cannot strand the counter.
    phase_d = phase_q;
    if (bus.out_strobe) begin
      phase_d = (({1'b0, phase_q} + (R_W+1)'(1)) >= ratio) ? '0 : phase_q + R_W'(1);
    end

    // Comb stage: low-rate differentiators, each fed by the previous old value.
    comb_data_d = comb_data_q;
    comb_last_d = comb_last_q;
    if (load_tick) begin
      comb_data_d[1] = x_ext - comb_last_q[0];
      comb_last_d[0] = x_ext;
      for (int k = 1; k < STAGES; k++) begin
        comb_data_d[k+1] = comb_data_q[k] - comb_last_q[k];
        comb_last_d[k]   = comb_data_q[k];
      end
    end

    // Integrator stage: zero-stuffed comb output accumulated at the high rate.
    z            = load_tick ? comb_data_q[STAGES] : '0;
    integrator_d = integrator_q;
    out_data_d   = out_data_q;
    if (bus.out_strobe) begin
      integrator_d[1] = integrator_q[1] + z;
      for (int k = 1; k < STAGES; k++) begin
        integrator_d[k+1] = integrator_q[k+1] + integrator_q[k];
      end
      out_data_d = rounded;
    end

    out_valid_d = bus.out_strobe;

    // A new underflow outranks a coincident clear.
    underflow_d = underflow_q;
    if (load_tick && !bus.in_valid) underflow_d = 1'b1;
    else if (clear_underflow)       underflow_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        comb_data_q[k]  <= '0;
        integrator_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        comb_last_q[k] <= '0;
      end
    end else begin
      phase_q      <= phase_d;
      comb_data_q  <= comb_data_d;
      comb_last_q  <= comb_last_d;
      integrator_q <= integrator_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.in_ready  = load_tick;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: a one-stage instance (dut_a) for the
// impulse/underflow sequences and a five-stage instance (dut_b) for DC gain,
// strobe spacing, ratio change and mid-stream reset.
module tb_cic_interpolator;
  import cic_pkg::*;

  logic       clock;
  logic       reset_n;
  logic [5:0] interp_a, interp_b;
  logic       clr_a, clr_b;
  logic       uf_a, uf_b;

  cic_interpolator_if #(.IN_WIDTH(18), .OUT_WIDTH(18)) if_a ();
  cic_interpolator_if #(.IN_WIDTH(18), .OUT_WIDTH(18)) if_b ();

  cic_interpolator #(
    .STAGES(1), .MIN_INTERPOLATION(2), .MAX_INTERPOLATION(40),
    .IN_WIDTH(18), .OUT_WIDTH(18)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .interpolation(interp_a),
    .clear_underflow(clr_a), .underflow(uf_a), .bus(if_a)
  );

  cic_interpolator #(
    .STAGES(5), .MIN_INTERPOLATION(2), .MAX_INTERPOLATION(40),
    .IN_WIDTH(18), .OUT_WIDTH(18)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .interpolation(interp_b),
    .clear_underflow(clr_b), .underflow(uf_b), .bus(if_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic signed [17:0] din;
    logic               rdy;
    logic signed [17:0] dout;
  } vec_t;

  vec_t vt [14];

  initial begin
    // Impulse through one stage, R=4: a zero-order hold of 4 ticks that
    // appears after tick N*R+N = 5.
    vt[0]  = '{18'sd1000, 1'b1, 18'sd0};
    vt[1]  = '{18'sd0,    1'b0, 18'sd0};
    vt[2]  = '{18'sd0,    1'b0, 18'sd0};
    vt[3]  = '{18'sd0,    1'b0, 18'sd0};
    vt[4]  = '{18'sd0,    1'b1, 18'sd0};
    vt[5]  = '{18'sd0,    1'b0, 18'sd1000};
    vt[6]  = '{18'sd0,    1'b0, 18'sd1000};
    vt[7]  = '{18'sd0,    1'b0, 18'sd1000};
    vt[8]  = '{18'sd0,    1'b1, 18'sd1000};
    vt[9]  = '{18'sd0,    1'b0, 18'sd0};
    vt[10] = '{18'sd0,    1'b0, 18'sd0};
    vt[11] = '{18'sd0,    1'b0, 18'sd0};
    vt[12] = '{18'sd0,    1'b1, 18'sd0};
    vt[13] = '{18'sd0,    1'b0, 18'sd0};

    reset_n = 1'b0;
    interp_a = 6'd4;  interp_b = 6'd8;
    clr_a = 1'b0;     clr_b = 1'b0;
    if_a.out_strobe = 1'b0; if_a.in_valid = 1'b0; if_a.in_data = '0;
    if_b.out_strobe = 1'b0; if_b.in_valid = 1'b0; if_b.in_data = '0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    check("rst_a_out",  if_a.out_data,  0);
    check("rst_a_vld",  if_a.out_valid, 0);
    check("rst_a_uf",   uf_a,           0);
    check("rst_b_out",  if_b.out_data,  0);
    check("rst_b_vld",  if_b.out_valid, 0);
    check("rst_b_uf",   uf_b,           0);
    reset_n = 1'b1;
    step();

    // N=1, R=4 impulse
    for (int t = 0; t < 14; t++) begin
      if_a.in_valid = 1'b1;
      if_a.in_data = vt[t].din;
      if_a.out_strobe = 1'b1;
      #1;
      check("imp_ready", if_a.in_ready, vt[t].rdy);
      step();
      check("imp_out", if_a.out_data, vt[t].dout);
      check("imp_vld", if_a.out_valid, 1);
    end
    if_a.out_strobe = 1'b0;

    // N=5, R=8, DC 1000 then full negative scale
    pulse_reset();
    interp_b = 6'd8;
    if_b.in_valid = 1'b1;
    if_b.in_data = 18'sd1000;
    if_b.out_strobe = 1'b1;
    repeat (150) step();
    for (int t = 0; t < 16; t++) begin
      step();
      check("dc_pos_out", if_b.out_data, 1000);
      check("dc_pos_vld", if_b.out_valid, 1);
    end
    if_b.in_data = -18'sd131072;
    repeat (150) step();
    for (int t = 0; t < 8; t++) begin
      step();
      check("dc_neg_out", if_b.out_data, -131072);
    end

    // N=5, R=5, strobe every third cycle; DC 1000 settles to 153 since
    // 1000*625/4096 = 152.59 rounds up.
    if_b.out_strobe = 1'b0;
    pulse_reset();
    interp_b = 6'd5;
    if_b.in_data = 18'sd1000;
    for (int c = 0; c < 360; c++) begin
      if_b.out_strobe = (c % 3 == 0);
      #1;
      if (c < 60) check("spc_ready", if_b.in_ready, ((c % 3 == 0) && ((c / 3) % 5 == 0)));
      step();
      if (c < 60) check("spc_vld", if_b.out_valid, (c % 3 == 0));
      if (c >= 330) check("spc_out", if_b.out_data, 153);
    end
    if_b.out_strobe = 1'b0;

    // N=1, R=4 DC 1000 with dropped samples and underflow clears
    pulse_reset();
    interp_a = 6'd4;
    if_a.in_data = 18'sd1000;
    for (int t = 0; t < 21; t++) begin
      if_a.out_strobe = 1'b1;
      if_a.in_valid = !(t == 8 || t == 20);
      clr_a = (t == 10 || t == 20);
      #1;
      if (t == 8) check("uf_ready_novalid", if_a.in_ready, 1);
      step();
      case (t)
        6:  check("uf_out_t6",  if_a.out_data, 1000);
        7:  check("uf_flag_t7", uf_a, 0);
        8:  check("uf_flag_t8", uf_a, 1);
        9:  check("uf_sticky",  uf_a, 1);
        10: begin
              check("uf_clear",  uf_a, 0);
              check("uf_out_t10", if_a.out_data, 1000);
            end
        11: check("uf_stay0",   uf_a, 0);
        14: check("uf_zero_in", if_a.out_data, 0);
        18: check("uf_out_t18", if_a.out_data, 1000);
        20: check("uf_set_wins", uf_a, 1);
        default: ;
      endcase
    end
    clr_a = 1'b0;
    if_a.out_strobe = 1'b0;

    // N=5: R 40 -> 2 at phase 30, then reset mid-stream
    pulse_reset();
    interp_b = 6'd40;
    if_b.in_valid = 1'b1;
    if_b.in_data = 18'sd1000;
    for (int t = 0; t < 34; t++) begin
      if (t == 30) interp_b = 6'd2;
      if_b.out_strobe = 1'b1;
      #1;
      if (t == 29) check("rchg_ready_t29", if_b.in_ready, 0);
      if (t == 30) check("rchg_ready_t30", if_b.in_ready, 0);
      if (t == 31) check("rchg_ready_t31", if_b.in_ready, 1);
      if (t == 32) check("rchg_ready_t32", if_b.in_ready, 0);
      if (t == 33) check("rchg_ready_t33", if_b.in_ready, 1);
      step();
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", if_b.out_data,  0);
    check("mid_rst_vld", if_b.out_valid, 0);
    check("mid_rst_uf",  uf_b,           0);
    step();
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", if_b.in_ready, 1);
    repeat (100) step();
    for (int t = 0; t < 8; t++) begin
      step();
      check("post_rst_dc", if_b.out_data, 1000);
    end
    if_b.out_strobe = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
